// File: rtl/id_branch_predictor.sv
// rtl/id_branch_predictor.sv - direct-mapped BTB with saturating-counter direction prediction
module id_branch_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  pred_valid,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [31:0]           hit_count,
    output logic [31:0]           mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] up_idx, lk_idx;
    logic [TAG_BITS-1:0]   up_tag, lk_tag;
    logic                  up_hit, up_write;
    logic                  new_valid;
    logic [TAG_BITS-1:0]   new_tag;
    logic [ADDR_WIDTH-1:0] new_target;
    logic [CTR_BITS-1:0]   new_ctr;

    logic                  bypass, lk_valid, lk_hit, lk_taken;
    logic [TAG_BITS-1:0]   lk_tag_stored;
    logic [ADDR_WIDTH-1:0] lk_target;
    logic [CTR_BITS-1:0]   lk_ctr;
    logic                  lookup_live;
    logic                  unused_pc_bits;

    assign up_idx = upd_pc[INDEX_BITS+1:2];
    assign up_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign lk_idx = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Post-update image of the entry at up_idx; also feeds the write-first bypass.
    always_comb begin
        up_write   = 1'b0;
        new_valid  = valid_q[up_idx];
        new_tag    = tag_q[up_idx];
        new_target = target_q[up_idx];
        new_ctr    = ctr_q[up_idx];
        if (upd_valid) begin
            if (up_hit) begin
                up_write = 1'b1;
                if (upd_taken) begin
                    new_target = upd_target;
                    if (new_ctr != CTR_MAX) new_ctr = new_ctr + CTR_BITS'(1);
                end else if (new_ctr != '0) begin
                    new_ctr = new_ctr - CTR_BITS'(1);
                end
            end else if (upd_taken) begin
                up_write   = 1'b1;
                new_valid  = 1'b1;
                new_tag    = up_tag;
                new_target = upd_target;
                new_ctr    = CTR_WEAK;
            end
        end
    end

    assign bypass        = up_write && (lk_idx == up_idx);
    assign lk_valid      = bypass ? new_valid  : valid_q[lk_idx];
    assign lk_tag_stored = bypass ? new_tag    : tag_q[lk_idx];
    assign lk_target     = bypass ? new_target : target_q[lk_idx];
    assign lk_ctr        = bypass ? new_ctr    : ctr_q[lk_idx];
    assign lk_hit        = lk_valid && (lk_tag_stored == lk_tag);
    assign lk_taken      = lk_hit && lk_ctr[CTR_BITS-1];
    assign lookup_live   = !stall && lookup_valid && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
        end else if (up_write) begin
            valid_q[up_idx]  <= new_valid;
            tag_q[up_idx]    <= new_tag;
            target_q[up_idx] <= new_target;
            ctr_q[up_idx]    <= new_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!stall) begin
            pred_valid  <= lookup_valid && !flush;
            pred_hit    <= lk_hit;
            pred_taken  <= lk_taken;
            pred_target <= lk_taken ? lk_target : '0;
        end else if (flush) begin
            pred_valid  <= 1'b0;
        end
    end

    assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                      (upd_taken && (upd_target != upd_pred_target)));
    // Not-taken resumes past the delay slot, hence +8.
    assign redirect_addr = !mispredict ? '0 :
                           upd_taken   ? upd_target : upd_pc + ADDR_WIDTH'(8);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count        <= '0;
            mispredict_count <= '0;
        end else begin
            if (lookup_live && lk_hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (mispredict && mispredict_count != 32'hFFFF_FFFF)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_id_branch_predictor.sv
// tb/tb_id_branch_predictor.sv - randomized and directed checks of id_branch_predictor against a table model
module tb_id_branch_predictor;
    localparam int AW = 32, IB = 6, TB = 8, CB = 2;
    localparam int NE = 1 << IB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int CWEAK = 1 << (CB - 1);

    logic          clk = 1'b0;
    logic          rst, lookup_valid, stall, flush;
    logic [AW-1:0] lookup_pc;
    logic          pred_valid, pred_hit, pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid, upd_taken, upd_pred_taken;
    logic [AW-1:0] upd_pc, upd_target, upd_pred_target;
    logic          mispredict;
    logic [AW-1:0] redirect_addr;
    logic [31:0]   hit_count, mispredict_count;

    id_branch_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .TAG_BITS(TB), .CTR_BITS(CB)) dut (
        .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .stall(stall), .flush(flush), .pred_valid(pred_valid), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_target(pred_target), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_addr(redirect_addr),
        .hit_count(hit_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    bit            m_valid  [NE];
    int            m_tag    [NE];
    logic [AW-1:0] m_target [NE];
    int            m_ctr    [NE];
    logic          e_pv, e_hit, e_taken;
    logic [AW-1:0] e_target;
    logic [31:0]   e_hcnt, e_mcnt;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(logic [AW-1:0] pc);
        return int'((pc >> 2) & (NE - 1));
    endfunction

    function automatic int tag_of(logic [AW-1:0] pc);
        return int'((pc >> (IB + 2)) & ((1 << TB) - 1));
    endfunction

    task automatic idle();
        rst = 0; lookup_valid = 0; lookup_pc = '0; stall = 0; flush = 0;
        upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
        upd_pred_taken = 0; upd_pred_target = '0;
    endtask

    task automatic upd(logic [AW-1:0] pc, logic tk, logic [AW-1:0] tgt, logic ptk, logic [AW-1:0] ptgt);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic look(logic [AW-1:0] pc);
        lookup_valid = 1; lookup_pc = pc;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        logic exp_mis;
        logic [AW-1:0] exp_red;
        int i, t;
        bit h;
        #1;
        exp_mis = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target));
        exp_red = !exp_mis ? '0 : (upd_taken ? upd_target : upd_pc + 8);
        check("mispredict", {31'b0, mispredict}, {31'b0, exp_mis});
        check("redirect_addr", redirect_addr, exp_red);
        if (rst) begin
            for (int k = 0; k < NE; k++) begin m_valid[k] = 0; m_ctr[k] = 0; end
            e_pv = 0; e_hit = 0; e_taken = 0; e_target = '0; e_hcnt = 0; e_mcnt = 0;
        end else begin
            if (exp_mis && e_mcnt != 32'hFFFF_FFFF) e_mcnt++;
            if (upd_valid) begin
                i = idx_of(upd_pc); t = tag_of(upd_pc);
                if (m_valid[i] && m_tag[i] == t) begin
                    if (upd_taken) begin
                        m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
                        m_target[i] = upd_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1; m_tag[i] = t; m_target[i] = upd_target; m_ctr[i] = CWEAK;
                end
            end
            if (!stall) begin
                i = idx_of(lookup_pc);
                h = m_valid[i] && m_tag[i] == tag_of(lookup_pc);
                e_hit = h;
                e_taken = h && m_ctr[i] >= CWEAK;
                e_target = e_taken ? m_target[i] : '0;
                e_pv = lookup_valid && !flush;
                if (e_pv && h && e_hcnt != 32'hFFFF_FFFF) e_hcnt++;
            end else if (flush) begin
                e_pv = 0;
            end
        end
        @(posedge clk);
        #1;
        check("pred_valid", {31'b0, pred_valid}, {31'b0, e_pv});
        if (e_pv) begin
            check("pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
            check("pred_taken", {31'b0, pred_taken}, {31'b0, e_taken});
            check("pred_target", pred_target, e_target);
        end
        check("hit_count", hit_count, e_hcnt);
        check("mispredict_count", mispredict_count, e_mcnt);
    endtask

    localparam logic [AW-1:0] PA = 32'h0040_0010;
    localparam logic [AW-1:0] PB = 32'h0040_1010;
    localparam logic [AW-1:0] PC = 32'h0040_0020;

    initial begin
        idle();
        rst = 1; step(); idle();
        check("rst_pred_valid", {31'b0, pred_valid}, 32'd0);
        check("rst_pred_target", pred_target, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_mis_count", mispredict_count, 32'd0);

        look(PA); step(); idle();
        check("t1_valid", {31'b0, pred_valid}, 32'd1);
        check("t1_hit", {31'b0, pred_hit}, 32'd0);
        check("t1_taken", {31'b0, pred_taken}, 32'd0);
        check("t1_target", pred_target, 32'd0);

        upd(PA, 1, 32'h0040_0040, 0, 32'h0);
        #1; check("t2_mis", {31'b0, mispredict}, 32'd1);
        check("t2_redirect", redirect_addr, 32'h0040_0040);
        step(); idle();
        check("t2_model_ctr", m_ctr[idx_of(PA)], 32'd2);
        look(PA); step(); idle();
        check("t2_hit", {31'b0, pred_hit}, 32'd1);
        check("t2_taken", {31'b0, pred_taken}, 32'd1);
        check("t2_target", pred_target, 32'h0040_0040);

        for (int k = 0; k < 2; k++) begin
            upd(PA, 1, 32'h0040_0040, 1, 32'h0040_0040); step(); idle();
            check("t3_ctr_up", m_ctr[idx_of(PA)], 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            upd(PA, 0, 32'h0040_0040, 1, 32'h0040_0040);
            #1; check("t3_mis", {31'b0, mispredict}, 32'd1);
            check("t3_redirect", redirect_addr, 32'h0040_0018);
            step(); idle();
            check("t3_ctr_down", m_ctr[idx_of(PA)], 32'(2 - k));
            if (k == 1) begin
                look(PA); step(); idle();
                check("t3_taken_off", {31'b0, pred_taken}, 32'd0);
            end
        end
        check("t3_mis_count", mispredict_count, 32'd4);
        check("t3_hit_count", hit_count, 32'd2);

        look(PB); step(); idle();
        check("t4_alias_miss", {31'b0, pred_hit}, 32'd0);
        upd(PB, 1, 32'h0040_0080, 0, 32'h0); step(); idle();
        look(PA); step(); idle();
        check("t4_evicted", {31'b0, pred_hit}, 32'd0);

        upd(PC, 1, 32'h0040_0100, 0, 32'h0); look(PC); step(); idle();
        check("t5_hit", {31'b0, pred_hit}, 32'd1);
        check("t5_target", pred_target, 32'h0040_0100);

        for (int k = 0; k < 3; k++) begin
            stall = 1; look(PA); step(); idle();
            check("t6_hold_valid", {31'b0, pred_valid}, 32'd1);
            check("t6_hold_target", pred_target, 32'h0040_0100);
        end
        stall = 1; flush = 1; look(PC); step(); idle();
        check("t6_flush", {31'b0, pred_valid}, 32'd0);
        look(PC); step(); idle();
        check("t6_relook", {31'b0, pred_hit}, 32'd1);
        rst = 1; look(PC); step(); idle();
        check("t6_rst_valid", {31'b0, pred_valid}, 32'd0);
        check("t6_rst_hit", {31'b0, pred_hit}, 32'd0);
        check("t6_rst_hcnt", hit_count, 32'd0);
        check("t6_rst_mcnt", mispredict_count, 32'd0);
        look(PC); step(); idle();
        check("t6_rst_miss", {31'b0, pred_hit}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] pc_l, pc_u, tg;
            pc_l = 32'h0040_0000 | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 2);
            pc_u = 32'h0040_0000 | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 2);
            tg = 32'h0040_1000 + ($urandom_range(0, 3) << 4);
            idle();
            rst = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) != 0) look(pc_l);
            if ($urandom_range(0, 2) != 0)
                upd(pc_u, 1'($urandom_range(0, 1)), tg, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? tg : 32'h0040_1000 + ($urandom_range(0, 3) << 4));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
